// File: rtl/mult8u_product_accumulator.sv
// Dot-product back end: sums a stream of unsigned products and presents each
// closed sum on a single-entry valid/ready output register.
module mult8u_product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and ready depends only on out_ready.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [ACC_W-1:0] base_acc;
    logic [CNT_W-1:0] base_cnt;
    logic             base_ovf;
    logic [ACC_W:0]   add_w;
    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_inc;
    logic             term_ovf;
    logic             accept;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // clear makes a same-cycle beat the first term of a fresh sum
        base_acc = clear ? '0 : acc_q;
        base_cnt = clear ? '0 : cnt_q;
        base_ovf = clear ? 1'b0 : ovf_q;
        add_w    = {1'b0, base_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
        cnt_sat  = (base_cnt == CNT_MAX);
        cnt_inc  = cnt_sat ? CNT_MAX : base_cnt + 1'b1;
        term_ovf = base_ovf | add_w[ACC_W] | cnt_sat;
    end

    always_comb begin
        acc_d       = base_acc;
        cnt_d       = base_cnt;
        ovf_d       = base_ovf;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            if (in_last) begin
                out_valid_d = 1'b1;
                out_sum_d   = add_w[ACC_W-1:0];
                out_count_d = cnt_inc;
                out_ovf_d   = term_ovf;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = add_w[ACC_W-1:0];
                cnt_d = cnt_inc;
                ovf_d = term_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
